// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder and the array controller.
// Holds the default geometry and the feeder state encoding.
package systolic_pkg;

  localparam int unsigned DIM_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2
  } feeder_state_t;

  // Number of skewed wavefronts needed to stream a dim x dim matrix.
  function automatic int unsigned wave_count(input int unsigned dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One output lane of the feeder: selects column element A[t-LANE][LANE],
// which realises a LANE-cycle skew relative to lane 0.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned LANE = 0,
  parameter int unsigned DIM  = DIM_DEFAULT,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned TW   = $clog2(2 * DIM_DEFAULT)
) (
  input  logic              en,
  input  logic [TW-1:0]     t,
  input  logic [DIM*DW-1:0] col,
  output logic [DW-1:0]     lane
);

  // Lane is zero before its first element and after its last one.
  always_comb begin
    lane = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      if (en && (32'(t) == r + LANE)) begin
        lane = col[r*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers a DIM x DIM matrix row by row, then streams it as 2*DIM-1 skewed
// wavefronts into a systolic array under valid/ready flow control.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DIM = DIM_DEFAULT,
  parameter int unsigned DW  = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIM*DW-1:0] in_row,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DIM*DW-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned   TW    = $clog2(2 * DIM);
  localparam int unsigned   RW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [TW-1:0] TLAST = TW'(wave_count(DIM) - 1);
  localparam logic [RW-1:0] RLAST = RW'(DIM - 1);

  feeder_state_t     state, state_n;
  logic [RW-1:0]     rcnt;
  logic [TW-1:0]     t;
  logic              ready_en;
  logic              accept;
  logic              fire;
  logic [DIM*DW-1:0] mem [DIM];
  logic [DIM*DW-1:0] lanes;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en && (state != FEED);
  assign out_valid = (state == FEED);
  assign out_first = out_valid && (t == '0);
  assign out_last  = out_valid && (t == TLAST);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = (DIM == 1) ? FEED : LOAD;
      LOAD: if (accept && (rcnt == RLAST)) state_n = FEED;
      FEED: if (fire && (t == TLAST)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rcnt     <= '0;
      t        <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      if (accept) begin
        rcnt <= (rcnt == RLAST) ? '0 : rcnt + 1'b1;
      end
      if (state != FEED) begin
        t <= '0;
      end else if (fire) begin
        t <= (t == TLAST) ? '0 : t + 1'b1;
      end
    end
  end

  // Row buffer carries no reset; it is only read while in FEED.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[rcnt] <= in_row;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DIM*DW-1:0] col;
    for (genvar r = 0; r < DIM; r++) begin : g_col
      assign col[r*DW +: DW] = mem[r][i*DW +: DW];
    end
    systolic_skew_lane #(
      .LANE(i),
      .DIM (DIM),
      .DW  (DW),
      .TW  (TW)
    ) u_lane (
      .en  (out_valid),
      .t   (t),
      .col (col),
      .lane(lanes[i*DW +: DW])
    );
  end

  assign out_data = lanes;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed-plus-random bench for systolic_feeder (DIM=4 and DIM=1 instances)
// against a matrix-level wavefront model.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_row = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        busy;

  logic        u_in_valid = 1'b0;
  logic        u_in_ready;
  logic [7:0]  u_in_row = '0;
  logic        u_out_ready = 1'b1;
  logic        u_out_valid;
  logic [7:0]  u_out_data;
  logic        u_out_first;
  logic        u_out_last;
  logic        u_busy;

  int checks = 0;
  int failures = 0;
  int unsigned amat [4][4];

  always #5 clk = ~clk;

  systolic_feeder #(.DIM(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .busy(busy)
  );

  systolic_feeder #(.DIM(1), .DW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_row(u_in_row), .out_ready(u_out_ready), .out_valid(u_out_valid),
    .out_data(u_out_data), .out_first(u_out_first), .out_last(u_out_last),
    .busy(u_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_of(input int r);
    logic [31:0] w = '0;
    for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(amat[r][c]);
    return w;
  endfunction

  // Wavefront t: lane i carries A[t-i][i] when that row exists, else zero.
  function automatic logic [31:0] exp_wave(input int t);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      if (t - i >= 0 && t - i < 4) w[i*8 +: 8] = 8'(amat[t-i][i]);
    end
    return w;
  endfunction

  task automatic fill_seq();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) amat[r][c] = 16 * r + c;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) amat[r][c] = $urandom_range(0, 255);
  endtask

  // Called at a falling edge; returns at the falling edge after row 3 is taken.
  task automatic load_matrix(input int gap, input bit keep_valid);
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      in_row   = row_of(r);
      check("in_ready_load", 64'(in_ready), 64'(1));
      if (r > 0) check("busy_load", 64'(busy), 64'(1));
      @(negedge clk);
      if (r < 3) check("no_out_in_load", 64'(out_valid), 64'(0));
      if (r == 1) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_row   = $urandom;
          @(negedge clk);
          check("gap_no_out", 64'(out_valid), 64'(0));
        end
      end
    end
    in_valid = keep_valid;
    in_row   = $urandom;
  endtask

  task automatic feed_check(input int stall_t, input int nstall, input int stop_t);
    int t = 0;
    int cyc = 0;
    int stalled = 0;
    while (t < 7 && t != stop_t && cyc < 40) begin
      check("out_valid", 64'(out_valid), 64'(1));
      check("out_data", 64'(out_data), 64'(exp_wave(t)));
      check("out_first", 64'(out_first), 64'(t == 0));
      check("out_last", 64'(out_last), 64'(t == 6));
      check("in_ready_feed", 64'(in_ready), 64'(0));
      check("busy_feed", 64'(busy), 64'(1));
      if (t == stall_t && stalled < nstall) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (out_ready) t++;
    end
    out_ready = 1'b1;
    if (stop_t >= 7) begin
      check("feed_cycles", 64'(cyc), 64'(7 + nstall));
      check("idle_valid", 64'(out_valid), 64'(0));
      check("idle_data", 64'(out_data), 64'(0));
      check("idle_flags", {62'(0), out_first, out_last}, 64'(0));
      check("bubble_ready", 64'(in_ready), 64'(1));
      check("idle_busy", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_u_in_ready", 64'(u_in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_ready_low", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("post_rst_ready_high", 64'(in_ready), 64'(1));
    check("post_rst_valid", 64'(out_valid), 64'(0));

    // Basic feed with A[r][c] = 16r+c.
    fill_seq();
    load_matrix(0, 1'b0);
    check("t3_literal", 64'(exp_wave(3)), 64'(32'h03122130));
    feed_check(-1, 0, 7);

    // Input gap of two cycles between rows 1 and 2.
    fill_rand();
    load_matrix(2, 1'b0);
    feed_check(-1, 0, 7);

    // Backpressure: three stall cycles at t=2.
    fill_seq();
    load_matrix(0, 1'b0);
    feed_check(2, 3, 7);

    // in_valid held through FEED; next matrix follows right after the bubble.
    fill_rand();
    load_matrix(0, 1'b1);
    feed_check(-1, 0, 7);
    fill_rand();
    load_matrix(0, 1'b0);
    feed_check(1, 1, 7);

    // Reset mid-FEED at t=4.
    fill_rand();
    load_matrix(0, 1'b0);
    feed_check(-1, 0, 4);
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_data", 64'(out_data), 64'(0));
    check("arst_ready", 64'(in_ready), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_flags", {62'(0), out_first, out_last}, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rerst_ready", 64'(in_ready), 64'(1));
    fill_rand();
    load_matrix(0, 1'b0);
    feed_check(-1, 0, 7);

    // Reset mid-LOAD: the partial matrix must never appear.
    fill_rand();
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1;
      in_row   = row_of(r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("load_abandon_valid", 64'(out_valid), 64'(0));
    end
    fill_rand();
    load_matrix(0, 1'b0);
    feed_check(-1, 0, 7);

    // DIM=1 instance.
    u_in_valid = 1'b1;
    u_in_row   = 8'h5A;
    check("d1_in_ready", 64'(u_in_ready), 64'(1));
    @(negedge clk);
    u_in_valid  = 1'b0;
    u_in_row    = 8'hFF;
    check("d1_valid", 64'(u_out_valid), 64'(1));
    check("d1_data", 64'(u_out_data), 64'(8'h5A));
    check("d1_first_last", {62'(0), u_out_first, u_out_last}, 64'(3));
    check("d1_ready_feed", 64'(u_in_ready), 64'(0));
    u_out_ready = 1'b0;
    @(negedge clk);
    check("d1_hold_valid", 64'(u_out_valid), 64'(1));
    check("d1_hold_data", 64'(u_out_data), 64'(8'h5A));
    u_out_ready = 1'b1;
    @(negedge clk);
    check("d1_idle_valid", 64'(u_out_valid), 64'(0));
    check("d1_idle_ready", 64'(u_in_ready), 64'(1));
    check("d1_idle_busy", 64'(u_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DIM, default 4: number of array rows and columns (square matrix).
REQ-002 SHALL have parameter DW, default 8: element width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_row holds a valid matrix row.
REQ-006 SHALL have port in_ready  output  1  feeder accepts a row this cycle.
REQ-007 SHALL have port in_row  input  DIM*DW  one row of A; element c occupies bits [c*DW +: DW].
REQ-008 SHALL have port out_ready  input  1  the array accepts a wavefront this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid wavefront.
REQ-010 SHALL have port out_data  output  DIM*DW  skewed wavefront; lane i occupies bits [i*DW +: DW].
REQ-011 SHALL have port out_first  output  1  marks wavefront 0 of a matrix.
REQ-012 SHALL have port out_last  output  1  marks wavefront 2*DIM-2 of a matrix.
REQ-013 SHALL have port busy  output  1  high in LOAD or FEED.

Function
REQ-014 SHALL implement a state machine with states IDLE, LOAD and FEED.
REQ-015 SHALL assert in_ready in IDLE and LOAD, and deassert it in FEED.
REQ-016 SHALL capture in_row into buffer row r on each cycle with in_valid and in_ready both high, r = 0..DIM-1 in arrival order.
REQ-017 SHALL move IDLE->LOAD on the first accepted row, or directly IDLE->FEED when DIM=1.
REQ-018 SHALL move LOAD->FEED on the cycle the DIM-th row is accepted.
REQ-019 SHALL ignore in_row whenever in_valid is low and hold the buffer.
REQ-020 SHALL in FEED keep a wavefront counter t = 0..2*DIM-2, starting at 0 on FEED entry.
REQ-021 SHALL hold out_valid high for the whole of FEED.
REQ-022 SHALL drive out_data lane i with A[t-i][i] when 0 <= t-i < DIM, else zero, so lane i is delayed by i cycles.
REQ-023 SHALL advance t only on a cycle with out_valid and out_ready both high; with out_ready low, t and out_data SHALL hold.
REQ-024 SHALL assert out_first when t=0 and out_last when t=2*DIM-2.
REQ-025 SHALL move FEED->IDLE when the t=2*DIM-2 wavefront is accepted.
REQ-026 SHALL accept the first row of the next matrix no earlier than the cycle after FEED->IDLE, giving one bubble cycle.
REQ-027 SHALL deassert out_valid, out_first and out_last outside FEED, and drive out_data to zero there.
REQ-028 SHALL have a latency of exactly one cycle from acceptance of the DIM-th row to out_valid high.
REQ-029 SHALL have a counter width of $clog2(2*DIM) bits and wrap nothing; the t range is bounded by REQ-025.

Reset
REQ-030 SHALL, while rst is low, force state IDLE, row count 0, t 0, in_ready 0, out_valid 0, out_first 0, out_last 0, busy 0 and out_data 0.
REQ-031 SHALL, on reset asserted mid-LOAD or mid-FEED, abandon the matrix immediately; partial rows SHALL never be emitted.
REQ-032 SHALL raise in_ready on the first clock edge after rst deasserts.
REQ-033 SHALL not require the buffer contents to be reset.

Structure
REQ-034 SHALL declare the state enum (IDLE, LOAD, FEED) and the DIM/DW defaults in a shared package, systolic_pkg, reused by the array controller.
REQ-035 SHALL implement the per-lane delay/select in one sub-module, systolic_skew_lane, instantiated DIM times with a lane-index parameter.

Verification
REQ-036 SHALL cover basic feed: DIM=4, DW=8, rows A[r][c]=16r+c sent back-to-back with out_ready=1 -> 7 wavefronts; t=0 gives lanes {00,0,0,0}; t=3 gives {30,21,12,03}; t=6 gives {0,0,0,33}; out_first on t=0, out_last on t=6.
REQ-037 SHALL cover input gaps: in_valid low for 2 cycles between rows 1 and 2 -> identical wavefronts; FEED is entered one cycle after row 3 is accepted.
REQ-038 SHALL cover backpressure: out_ready low for 3 cycles at t=2 -> out_data holds {20,11,02,0}; resumes at t=3; total FEED time is 10 cycles.
REQ-039 SHALL cover input blocking: in_valid held high during FEED -> in_ready=0, no row is captured, and the next matrix starts after out_last plus one bubble.
REQ-040 SHALL cover reset mid-FEED: rst low at t=4 -> out_valid=0 asynchronously; a subsequent new matrix produces a clean t=0 with its own data.
REQ-041 SHALL cover DIM=1: one row {0x5A} -> a single wavefront {0x5A} with out_first=out_last=1.
